// File: rtl/fp32_multiply_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fp32_multiply_seq_if
// Description : Operand/result handshake bundle for the sequential FP32
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp32_multiply_seq_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        outValid;
  logic        outReady;
  logic [31:0] out;

  modport master (
    output inValid, inputA, inputB, outReady,
    input  inReady, outValid, out
  );

  modport slave (
    input  inValid, inputA, inputB, outReady,
    output inReady, outValid, out
  );
endinterface
`default_nettype wire

// File: rtl/fp32_multiply_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_multiply_seq
// Description : Shift-add FP32 multiplier, one product bit per cycle,
//               truncating rounding, subnormals flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_multiply_seq #(
  parameter int MANT_BITS = 24,
  parameter int BIAS      = 127
) (
  input  wire logic       clk,
  input  wire logic       resetN,
  fp32_multiply_seq_if.slave bus
);

  localparam int             c_PROD_W = 2 * MANT_BITS;
  localparam int             c_CNT_W  = $clog2(MANT_BITS);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MANT_BITS - 1);
  localparam logic [9:0]     c_BIAS   = 10'(BIAS);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MULT = 2'd1;
  localparam logic [1:0] c_NORM = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]            r_state;
  logic                  r_sign;
  logic [MANT_BITS-1:0]  r_mantA;
  logic [MANT_BITS-1:0]  r_mantB;
  logic signed [9:0]     r_expSum;
  logic                  r_aInf;
  logic                  r_bInf;
  logic                  r_aZero;
  logic                  r_bZero;
  logic [c_PROD_W-1:0]   r_acc;
  logic [c_CNT_W-1:0]    r_count;
  logic [31:0]           r_out;
  logic                  r_outValid;

  logic [9:0]            w_expSumNext;
  logic [c_PROD_W-1:0]   w_addend;
  logic                  w_carry;
  logic signed [9:0]     w_expFinal;
  logic [MANT_BITS-2:0]  w_frac;
  logic [31:0]           w_result;

  assign w_expSumNext = {2'b00, bus.inputA[30:23]} + {2'b00, bus.inputB[30:23]} - c_BIAS;
  assign w_addend     = {{MANT_BITS{1'b0}}, r_mantA} << r_count;

  // A set top bit means the product lies in [2,4): shift right once more.
  assign w_carry    = r_acc[c_PROD_W-1];
  assign w_expFinal = r_expSum + {9'd0, w_carry};
  assign w_frac     = w_carry ? r_acc[c_PROD_W-2 -: MANT_BITS-1]
                              : r_acc[c_PROD_W-3 -: MANT_BITS-1];

  always_comb begin
    w_result = {r_sign, w_expFinal[7:0], w_frac};
    if ((r_aInf && r_bZero) || (r_bInf && r_aZero)) begin
      w_result = 32'h7FC0_0000;
    end else if (r_aInf || r_bInf) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (r_aZero || r_bZero) begin
      w_result = {r_sign, 31'd0};
    end else if (w_expFinal >= 10'sd255) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (w_expFinal <= 10'sd0) begin
      w_result = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= c_IDLE;
      r_sign     <= 1'b0;
      r_mantA    <= '0;
      r_mantB    <= '0;
      r_expSum   <= '0;
      r_aInf     <= 1'b0;
      r_bInf     <= 1'b0;
      r_aZero    <= 1'b0;
      r_bZero    <= 1'b0;
      r_acc      <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.inValid) begin
            r_sign   <= bus.inputA[31] ^ bus.inputB[31];
            r_mantA  <= {1'b1, bus.inputA[22:0]};
            r_mantB  <= {1'b1, bus.inputB[22:0]};
            r_expSum <= w_expSumNext;
            r_aInf   <= (bus.inputA[30:23] == 8'hFF);
            r_bInf   <= (bus.inputB[30:23] == 8'hFF);
            r_aZero  <= (bus.inputA[30:23] == 8'h00);
            r_bZero  <= (bus.inputB[30:23] == 8'h00);
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= c_MULT;
          end
        end
        c_MULT: begin
          if (r_mantB[r_count]) begin
            r_acc <= r_acc + w_addend;
          end
          if (r_count == c_LAST) begin
            r_state <= c_NORM;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        c_NORM: begin
          r_out      <= w_result;
          r_outValid <= 1'b1;
          r_state    <= c_DONE;
        end
        c_DONE: begin
          if (bus.outReady) begin
            r_outValid <= 1'b0;
            r_state    <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.inReady  = (r_state == c_IDLE);
  assign bus.outValid = r_outValid;
  assign bus.out      = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fp32_multiply_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_multiply_seq
// Description : Scoreboard bench for the sequential FP32 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_multiply_seq;

  logic clk;
  logic resetN;
  int   cyc;
  int   nChecked;
  int   nFailed;

  logic [31:0] expQ[$];
  int          monAccCyc;
  logic        monBusy;
  logic        monPrevValid;

  fp32_multiply_seq_if bus ();

  fp32_multiply_seq #(.MANT_BITS(24), .BIAS(127)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecked++;
    if (got !== exp) begin
      nFailed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] p;
    logic [22:0] f;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 1;
    end else begin
      f = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], f};
  endfunction

  // Driven from just after a rising edge; returns once the operand is taken.
  task automatic sendOp(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int accCyc);
    int waits;
    bus.inputA  = a;
    bus.inputB  = b;
    bus.inValid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.inReady && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.inReady) checkVal("acceptTimeout", {31'd0, bus.inReady}, 32'd1);
    accCyc = cyc + 1;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic waitDone();
    int waits;
    waits = 0;
    while (expQ.size() != 0 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    checkVal("drainQueue", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency, busy-time inReady and in-order results.
  always @(negedge clk) begin
    if (!resetN) begin
      monBusy      = 1'b0;
      monPrevValid = 1'b0;
    end else begin
      if (monBusy) checkVal("inReadyBusy", {31'd0, bus.inReady}, 32'd0);
      if (bus.outValid && !monPrevValid)
        checkVal("latency", 32'(cyc - monAccCyc), 32'd25);
      if (bus.outValid && bus.outReady) begin
        if (expQ.size() == 0) begin
          checkVal("spuriousValid", {31'd0, bus.outValid}, 32'd0);
        end else begin
          checkVal("result", bus.out, expQ.pop_front());
        end
        monBusy = 1'b0;
      end
      if (bus.inValid && bus.inReady) begin
        monAccCyc = cyc + 1;
        monBusy   = 1'b1;
      end
      monPrevValid = bus.outValid;
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];
  int   t0, t1, t2;

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    int          waits;
    logic        sawValid;

    nChecked     = 0;
    nFailed      = 0;
    monBusy      = 1'b0;
    monPrevValid = 1'b0;
    monAccCyc    = 0;
    resetN       = 1'b0;
    bus.inValid  = 1'b0;
    bus.inputA   = '0;
    bus.inputB   = '0;
    bus.outReady = 1'b1;

    vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[2] = '{32'hC0000000, 32'h3F000000, 32'hBF800000};
    vecs[3] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};
    vecs[4] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[5] = '{32'h80000000, 32'h40400000, 32'h80000000};
    vecs[6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[7] = '{32'h00800000, 32'h00800000, 32'h00000000};

    repeat (3) @(negedge clk);
    checkVal("rstInReady", {31'd0, bus.inReady}, 32'd1);
    checkVal("rstOutValid", {31'd0, bus.outValid}, 32'd0);
    checkVal("rstOut", bus.out, 32'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      sendOp(vecs[i].a, vecs[i].b, vecs[i].r, t0);
      waitDone();
    end

    for (int i = 0; i < 4; i++) begin
      ra = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
      sendOp(ra, rb, refMul(ra, rb), t0);
      waitDone();
    end

    // Backpressure: result must hold and fresh operands must be ignored.
    bus.outReady = 1'b0;
    sendOp(32'h40000000, 32'h40400000, 32'h40C00000, t0);
    waits = 0;
    while (!bus.outValid && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkVal("bpValid", {31'd0, bus.outValid}, 32'd1);
    held = bus.out;
    bus.inputA  = 32'h3F800000;
    bus.inputB  = 32'h3F800000;
    bus.inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal("bpStable", bus.out, held);
      checkVal("bpInReady", {31'd0, bus.inReady}, 32'd0);
      checkVal("bpValidHeld", {31'd0, bus.outValid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    checkVal("bpReleaseReady", {31'd0, bus.inReady}, 32'd1);
    checkVal("bpReleaseValid", {31'd0, bus.outValid}, 32'd0);
    checkVal("bpQueue", 32'(expQ.size()), 32'd0);

    // Reset in the middle of the multiply loop discards the operation.
    sendOp(32'h3FC00000, 32'h40400000, 32'h40900000, t0);
    repeat (12) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    checkVal("midRstInReady", {31'd0, bus.inReady}, 32'd1);
    checkVal("midRstOutValid", {31'd0, bus.outValid}, 32'd0);
    checkVal("midRstOut", bus.out, 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.outValid) sawValid = 1'b1;
    end
    checkVal("noStaleValid", {31'd0, sawValid}, 32'd0);
    @(posedge clk);
    #1;

    sendOp(32'h40000000, 32'h40400000, 32'h40C00000, t0);
    waitDone();

    // Back-to-back stream: operands offered again immediately after each accept.
    sendOp(vecs[1].a, vecs[1].b, vecs[1].r, t0);
    sendOp(vecs[2].a, vecs[2].b, vecs[2].r, t1);
    sendOp(vecs[0].a, vecs[0].b, vecs[0].r, t2);
    checkVal("spacing01", 32'(t1 - t0), 32'd27);
    checkVal("spacing12", 32'(t2 - t1), 32'd27);
    waitDone();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFailed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp32_multiply_seq.md
Name: fp32_multiply_seq

Overview:
- Sequential single-precision (IEEE-754 binary32) multiplier, the inverse operation of the datapath's FP32 divider.
- Accepts operand pairs over a valid/ready handshake and forms the 24x24 mantissa product by iterative shift-add, one bit per cycle.
- Normalizes and truncates the result, then holds it on a valid/ready output port.
- Sits in the TPU arithmetic pool wherever area matters more than throughput.

Parameters:
- MANT_BITS, 24, significand width including hidden 1; also the multiply iteration count.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- inValid  in  1  operand pair valid.
- inReady  out  1  block can accept operands.
- inputA  in  32  FP32 multiplicand.
- inputB  in  32  FP32 multiplier.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts result.
- out  out  32  FP32 product.

Behaviour:
- Reset: resetN low asynchronously forces IDLE, inReady=1, outValid=0, out=0, and clears all internal registers. This holds even mid-operation; the in-flight operation is discarded with no output.
- FSM states: IDLE, MULT, NORM, DONE.
- IDLE: inReady=1. On an edge with inValid=1, the block:
  - latches sign = A[31]^B[31];
  - latches both mantissas {1,frac};
  - latches expSum = eA+eB-BIAS, as 10-bit signed;
  - latches special flags;
  - clears the 48-bit accumulator and the counter;
  - moves to MULT.
- MULT: inReady=0. Each edge, if multiplier bit[counter] is 1, the accumulator adds multiplicand<<counter. After 24 edges (counter 0..23) the state moves to NORM.
- NORM, one edge:
  - If product bit47=1: frac=p[46:24] and exp=expSum+1.
  - Otherwise: frac=p[45:23] and exp=expSum.
  - Rounding is truncation only (toward zero).
  - The result is registered into out; outValid=1; the state moves to DONE.
- Exceptions, resolved in NORM with priority top-down:
  - any input with exponent field 255 while the other input has exponent field 0 -> out=0x7FC00000;
  - any input with exponent field 255 -> {sign,0xFF,0};
  - any input with exponent field 0 -> {sign,0x00,0}, i.e. subnormals are flushed to signed zero;
  - final exp >= 255 -> {sign,0xFF,0};
  - final exp <= 0 -> {sign,0x00,0}.
- DONE: outValid=1 and out is held stable until outReady=1. On that edge outValid drops, inReady rises, and the state returns to IDLE.
- Latency: fixed for all operands, special cases included. outValid is first high after the 25th edge following the accepting edge.
- Throughput: no overlap between operations. The minimum spacing between accepts is 27 edges with outReady tied high.
- Operand inputs are ignored outside IDLE. inValid held high during MULT/NORM/DONE has no effect.
- out changes only on the NORM edge or on reset.

Test Plan:
- Basic products:
  - inputA=0x40000000 (2.0), inputB=0x40400000 (3.0), outReady=1 -> out=0x40C00000, outValid high exactly 25 edges after accept, inReady low throughout.
  - 0x3FC00000 x 0x3FC00000 -> 0x40100000 (carry path, bit47=1).
  - 0xC0000000 x 0x3F000000 -> 0xBF800000 (sign XOR, no carry).
- Truncation: 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE.
- Specials:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000 (overflow to inf).
  - 0x80000000 x 0x40400000 -> 0x80000000 (signed zero).
  - 0x7F800000 x 0x00000000 -> 0x7FC00000 (inf x zero -> NaN).
  - 0x00800000 x 0x00800000 -> 0x00000000 (underflow flush).
- Backpressure: outReady held low 10 cycles after outValid -> out stable, inReady=0, and a new inValid is ignored; outReady pulse -> inReady=1 on the next cycle.
- Reset and back-to-back:
  - resetN pulsed low mid-MULT (iteration 12) -> outputs immediately IDLE values, no stale outValid afterwards.
  - Next operation 0x40000000 x 0x40400000 -> 0x40C00000.
  - Back-to-back stream of 3 pairs with outReady=1 -> results in order with 27-edge spacing.
